// File: rtl/step_loader.sv
// step_loader: assembles a little-endian byte stream into 560-bit trace
// steps for the tiny86 core. Bytes 0..68 land in per-byte lanes; byte 69
// goes straight into the output register together with the lanes, so the
// step is presented one cycle after its last byte is accepted.

// One byte lane of the assembly buffer. No reset: every lane is rewritten
// before its contents are ever loaded into the output register.
module step_lane (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);
    // capture the byte addressed to this lane
    always_ff @(posedge clk) begin
        if (we) q <= d;
    end
endmodule

module step_loader #(
    parameter int STEP_BYTES = 70
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_sync,
    output logic                    in_ready,
    output logic [STEP_BYTES*8-1:0] step,
    output logic                    step_valid,
    input  logic                    step_ready,
    output logic [31:0]             step_count,
    output logic                    err_frame,
    input  logic                    err_clr
);
    localparam int         STEP_W   = STEP_BYTES * 8;
    localparam int         BUF_N    = STEP_BYTES - 1;
    localparam logic [6:0] LAST_IDX = 7'(STEP_BYTES - 1);

    generate
        if (STEP_BYTES != 70) begin : g_bad_size
            $error("step_loader supports only STEP_BYTES == 70");
        end
    endgenerate

    logic [6:0]             idx;
    logic [6:0]             wr_idx;
    logic                   acc;
    logic                   resync;
    logic                   last_acc;
    logic                   xfer;
    logic [BUF_N-1:0][7:0]  buf_q;

    // handshake decode; a sync mark always redirects the byte to slot 0
    always_comb begin
        acc      = in_valid & in_ready;
        wr_idx   = in_sync ? 7'd0 : idx;
        resync   = acc & in_sync & (idx != 7'd0);
        last_acc = acc & (wr_idx == LAST_IDX);
        xfer     = step_valid & step_ready;
        // only the final byte can stall: it needs the output register free
        in_ready = rst_n & ~((idx == LAST_IDX) & step_valid & ~step_ready);
    end

    genvar i;
    generate
        for (i = 0; i < BUF_N; i++) begin : g_lane
            step_lane u_lane (
                .clk (clk),
                .we  (acc && (wr_idx == 7'(i))),
                .d   (in_data),
                .q   (buf_q[i])
            );
        end
    endgenerate

    // byte index: wraps after the last byte, restarts at 1 after a sync byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        idx <= '0;
        else if (last_acc) idx <= '0;
        else if (acc)      idx <= wr_idx + 7'd1;
    end

    // output register loads lanes plus the final byte in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        step <= '0;
        else if (last_acc) step <= {in_data, buf_q};
    end

    // valid holds until taken; a reload on the taking edge keeps it high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        step_valid <= 1'b0;
        else if (last_acc) step_valid <= 1'b1;
        else if (xfer)     step_valid <= 1'b0;
    end

    // handed-off step counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    step_count <= '0;
        else if (xfer) step_count <= step_count + 32'd1;
    end

    // sticky framing error; a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_frame <= 1'b0;
        else if (resync)  err_frame <= 1'b1;
        else if (err_clr) err_frame <= 1'b0;
    end

    logic unused_w;
    assign unused_w = ^STEP_W;
endmodule

// File: tb/tb_step_loader.sv
// Bench for step_loader: table-driven step vectors, hand-written corner
// sequences, and a scoreboard fed by a byte-level reference model.
module tb_step_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_sync = 1'b0;
    logic         in_ready;
    logic [559:0] step;
    logic         step_valid;
    logic         step_ready = 1'b0;
    logic [31:0]  step_count;
    logic         err_frame;
    logic         err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int rdy_mode = 0;

    logic [559:0] exp_q[$];
    logic [559:0] m_step = '0;
    int           m_idx = 0;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] stride;
        logic       sync;
        logic [7:0] exp_b0;
        logic [7:0] exp_b69;
    } vec_t;
    vec_t vecs[5];

    step_loader #(.STEP_BYTES(70)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_ready   (in_ready),
        .step       (step),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_count (step_count),
        .err_frame  (err_frame),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [559:0] act, input logic [559:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // step_ready driver, updated 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       step_ready = 1'b0;
            1:       step_ready = 1'b1;
            default: step_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // scoreboard: every transfer must match the oldest expected step
    always @(negedge clk) begin
        if (rst_n && step_valid && step_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra act=%0h exp=none", step);
            end else begin
                chk("sb_step", step, exp_q.pop_front());
            end
        end
    end

    task automatic model_accept(input logic [7:0] b, input logic s);
        if (s && m_idx != 0) m_idx = 0;
        m_step[8*m_idx +: 8] = b;
        if (m_idx == 69) begin
            exp_q.push_back(m_step);
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // offer one byte until accepted; starts and ends 1 unit after a rising edge
    task automatic send_byte(input logic [7:0] b, input logic s);
        bit done = 1'b0;
        in_data  = b;
        in_sync  = s;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(b, s);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout act=in_ready_low exp=accepted byte=%0h", b);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input logic [7:0] stride, input int k);
        return 8'(int'(seed) + k * int'(stride));
    endfunction

    task automatic send_range(input logic [7:0] seed, input logic [7:0] stride,
                              input int k0, input int k1, input logic sync0);
        for (int k = k0; k <= k1; k++) send_byte(pat(seed, stride, k), sync0 && (k == k0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 300 && (exp_q.size() != 0 || step_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {558'd0, exp_q.size() == 0, !step_valid}, 560'd3);
    endtask

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog act=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [559:0] a_exp;
        logic [559:0] b_exp;
        int           base;
        logic [7:0]   rb;

        vecs[0] = '{8'h00, 8'h01, 1'b1, 8'h00, 8'h45};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hBA};
        vecs[2] = '{8'h10, 8'h03, 1'b1, 8'h10, 8'hDF};
        vecs[3] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5};
        vecs[4] = '{8'h80, 8'h02, 1'b0, 8'h80, 8'h0A};

        // reset state
        #1 rst_n = 1'b0;
        #11;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_step", step, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_err_frame", err_frame, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // table-driven full steps with an always-ready consumer
        for (int i = 0; i < 5; i++) begin
            send_range(vecs[i].seed, vecs[i].stride, 0, 69, vecs[i].sync);
            @(negedge clk);
            chk("vec_valid_rise", step_valid, 1);
            chk("vec_b0", step[7:0], vecs[i].exp_b0);
            chk("vec_b69", step[559:552], vecs[i].exp_b69);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("vec_valid_fall", step_valid, 0);
            chk("vec_count", step_count, 32'(i + 1));
            chk("vec_err_none", err_frame, 0);
            @(posedge clk);
            #1;
        end

        // consumer stalled: last byte of second step waits, then both move
        rdy_mode = 0;
        send_range(8'h20, 8'h05, 0, 69, 1'b1);
        send_range(8'h61, 8'h07, 0, 68, 1'b0);
        a_exp = exp_q[0];
        for (int c = 0; c < 3; c++) begin
            in_data  = pat(8'h61, 8'h07, 69);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", step_valid, 1);
            chk("stall_step_held", step, a_exp);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        send_byte(pat(8'h61, 8'h07, 69), 1'b0);
        b_exp = exp_q[0];
        @(negedge clk);
        chk("b2b_valid_kept", step_valid, 1);
        chk("b2b_second_step", step, b_exp);
        @(posedge clk);
        #1;
        wait_drain();

        // framing error mid-step, then clear
        chk("frame_pre", err_frame, 0);
        send_range(8'h30, 8'h01, 0, 9, 1'b1);
        send_byte(8'hAA, 1'b1);
        @(negedge clk);
        chk("frame_set", err_frame, 1);
        @(posedge clk);
        #1;
        send_range(8'h40, 8'h01, 1, 69, 1'b0);
        @(negedge clk);
        chk("frame_b0", step[7:0], 8'hAA);
        chk("frame_valid", step_valid, 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("frame_clr", err_frame, 0);
        @(posedge clk);
        #1;

        // error and clear in the same cycle: error wins
        send_range(8'h50, 8'h01, 0, 2, 1'b1);
        err_clr = 1'b1;
        send_byte(8'h55, 1'b1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("frame_set_wins", err_frame, 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        send_range(8'h56, 8'h01, 1, 69, 1'b0);
        wait_drain();
        chk("frame_clr2", err_frame, 0);

        // reset in the middle of a step discards it
        send_range(8'h90, 8'h01, 0, 29, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_count", step_count, 0);
        chk("midrst_valid", step_valid, 0);
        m_idx = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_range(8'h77, 8'h0D, 0, 69, 1'b0);
        wait_drain();
        chk("midrst_one_step", step_count, 1);

        // counter wrap
        force dut.step_count = 32'hFFFF_FFFF;
        #1;
        release dut.step_count;
        @(negedge clk);
        chk("wrap_preset", step_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        send_range(8'h05, 8'h09, 0, 69, 1'b1);
        wait_drain();
        chk("wrap_zero", step_count, 0);

        // random backpressure on both sides
        rdy_mode = 2;
        base = xfers;
        for (int s = 0; s < 600; s++) begin
            for (int k = 0; k < 70; k++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                rb = 8'($urandom);
                send_byte(rb, (k == 0) && ($urandom_range(0, 1) == 1));
            end
        end
        rdy_mode = 1;
        wait_drain();
        chk("rand_xfers", 560'(xfers - base), 560'd600);
        chk("rand_err_none", err_frame, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
